// File: rtl/ln_log_compute.sv
// ln(F) from the leading-one position, through a 2-stage pipeline into a credit-controlled show-ahead FIFO.
// Optional macro LN_LINEAR_INTERP_EN adds linear interpolation between the 16 ln(1+x) ROM segments.
module ln_log_compute #(
  parameter int DATA_W     = 32,
  parameter int FRAC_BITS  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] f_in,
  input  logic [DATA_W-1:0] lod_w,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ln_out,
  output logic              out_zero
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SH_W  = $clog2(DATA_W) + 1;
  localparam logic [DATA_W-1:0] LN2_Q     = DATA_W'(45426);
  localparam logic [DATA_W-1:0] ZERO_CODE = {1'b1, {(DATA_W-1){1'b0}}};

  // round(ln(1+i/16) * 2^16)
  function automatic logic [15:0] c0_rom(input logic [3:0] idx);
    case (idx)
      4'd0:  return 16'd0;
      4'd1:  return 16'd3973;
      4'd2:  return 16'd7719;
      4'd3:  return 16'd11262;
      4'd4:  return 16'd14624;
      4'd5:  return 16'd17821;
      4'd6:  return 16'd20870;
      4'd7:  return 16'd23783;
      4'd8:  return 16'd26573;
      4'd9:  return 16'd29248;
      4'd10: return 16'd31818;
      4'd11: return 16'd34292;
      4'd12: return 16'd36675;
      4'd13: return 16'd38975;
      4'd14: return 16'd41196;
      default: return 16'd43345;
    endcase
  endfunction

`ifdef LN_LINEAR_INTERP_EN
  // Segment slope: c0[i+1] - c0[i], with c0[16] = ln2.
  function automatic logic [15:0] c1_rom(input logic [3:0] idx);
    case (idx)
      4'd0:  return 16'd3973;
      4'd1:  return 16'd3746;
      4'd2:  return 16'd3543;
      4'd3:  return 16'd3362;
      4'd4:  return 16'd3197;
      4'd5:  return 16'd3049;
      4'd6:  return 16'd2913;
      4'd7:  return 16'd2790;
      4'd8:  return 16'd2675;
      4'd9:  return 16'd2570;
      4'd10: return 16'd2474;
      4'd11: return 16'd2383;
      4'd12: return 16'd2300;
      4'd13: return 16'd2221;
      4'd14: return 16'd2149;
      default: return 16'd2081;
    endcase
  endfunction
`endif

  logic              w_accept;
  logic              w_pop;
  logic              w_fifo_nonempty;
  logic [CNT_W-1:0]  r_credits;

  logic              r_s1_v;
  logic [DATA_W-1:0] r_f_d;
  logic              w_s1_zero;
  logic signed [6:0] w_s1_e;
  logic [SH_W-1:0]   w_shamt;
  logic [3:0]        w_s1_idx;

  logic              r_s2_v;
  logic              r_s2_zero;
  logic signed [6:0] r_s2_e;
  logic [3:0]        r_s2_idx;
  logic [DATA_W-1:0] w_e_ext;
  logic [DATA_W-1:0] w_res;
  logic [DATA_W-1:0] w_push_data;

`ifdef LN_LINEAR_INTERP_EN
  logic [19:0]       w_sel;
  logic [15:0]       w_s1_dx;
  logic [15:0]       r_s2_dx;
  logic [15:0]       w_interp;
`endif

  logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
  logic              r_mem_zero [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_last_data;
  logic              r_last_zero;

  // Handshake and credits
  assign w_fifo_nonempty = (r_count != '0);
  assign out_valid       = rst & w_fifo_nonempty;
  assign in_ready        = rst & (r_credits < CNT_W'(FIFO_DEPTH));
  assign w_accept        = in_valid & in_ready;
  assign w_pop           = out_valid & out_ready;

  // S1: lod_w is registered upstream, so it lines up with r_f_d here
  assign w_s1_zero = (lod_w == '0);
  assign w_s1_e    = $signed(lod_w[6:0] - 7'(FRAC_BITS + 1));
  assign w_shamt   = SH_W'(DATA_W) - lod_w[SH_W-1:0];

`ifdef LN_LINEAR_INTERP_EN
  // Shifting the leading one to the MSB leaves idx at [DATA_W-2 -: 4] and dx just below it.
  assign w_sel    = 20'((r_f_d << w_shamt) >> (DATA_W - 21));
  assign w_s1_idx = w_sel[19:16];
  assign w_s1_dx  = w_sel[15:0];
`else
  assign w_s1_idx = 4'((r_f_d << w_shamt) >> (DATA_W - 5));
`endif

  // S2: e*ln2 + ln(1+x)
  assign w_e_ext = {{(DATA_W-7){r_s2_e[6]}}, r_s2_e};

`ifdef LN_LINEAR_INTERP_EN
  assign w_interp = 16'((32'(c1_rom(r_s2_idx)) * 32'(r_s2_dx)) >> 16);
  assign w_res    = w_e_ext * LN2_Q + DATA_W'(c0_rom(r_s2_idx)) + DATA_W'(w_interp);
`else
  assign w_res    = w_e_ext * LN2_Q + DATA_W'(c0_rom(r_s2_idx));
`endif

  assign w_push_data = r_s2_zero ? ZERO_CODE : w_res;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_f_d <= f_in;
    end
    if (r_s1_v) begin
      r_s2_e    <= w_s1_e;
      r_s2_idx  <= w_s1_idx;
      r_s2_zero <= w_s1_zero;
`ifdef LN_LINEAR_INTERP_EN
      r_s2_dx   <= w_s1_dx;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (r_s2_v) begin
      r_mem_data[r_wr_ptr] <= w_push_data;
      r_mem_zero[r_wr_ptr] <= r_s2_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1_v      <= 1'b0;
      r_s2_v      <= 1'b0;
      r_credits   <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_last_data <= '0;
      r_last_zero <= 1'b0;
    end else begin
      r_s1_v    <= w_accept;
      r_s2_v    <= r_s1_v;
      r_credits <= r_credits + CNT_W'(w_accept) - CNT_W'(w_pop);
      r_count   <= r_count + CNT_W'(r_s2_v) - CNT_W'(w_pop);
      if (r_s2_v) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      // Shadow of the head so an empty FIFO keeps presenting the last result
      if (w_fifo_nonempty) begin
        r_last_data <= r_mem_data[r_rd_ptr];
        r_last_zero <= r_mem_zero[r_rd_ptr];
      end
    end
  end

  always_comb begin
    ln_out   = '0;
    out_zero = 1'b0;
    if (rst) begin
      if (w_fifo_nonempty) begin
        ln_out   = r_mem_data[r_rd_ptr];
        out_zero = r_mem_zero[r_rd_ptr];
      end else begin
        ln_out   = r_last_data;
        out_zero = r_last_zero;
      end
    end
  end

endmodule

// File: tb/tb_ln_log_compute.sv
// Scoreboard bench for ln_log_compute; lod_w comes from a registered leading-one detector model.
module tb_ln_log_compute;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] f_in;
  logic [31:0] lod_w;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ln_out;
  logic        out_zero;

  always #5 clk = ~clk;

  ln_log_compute #(.DATA_W(32), .FRAC_BITS(16), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .f_in      (f_in),
    .lod_w     (lod_w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ln_out    (ln_out),
    .out_zero  (out_zero)
  );

  function automatic logic [31:0] lod_model(input logic [31:0] f);
    for (int i = 31; i >= 0; i--) begin
      if (f[i]) return 32'(i + 1);
    end
    return '0;
  endfunction

  always @(posedge clk) lod_w <= lod_model(f_in);

  typedef struct {
    logic [31:0] ln;
    logic        zero;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every beat the consumer takes is matched against the scoreboard head
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got ln_out=%h out_zero=%b, required no beat (t=%0t)",
                 ln_out, out_zero, $time);
      end else begin
        mon_e = sb.pop_front();
        check("ln_out", ln_out, mon_e.ln);
        check("out_zero", 32'(out_zero), 32'(mon_e.zero));
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] f, input logic [31:0] exp_ln, input logic exp_zero);
    bit done;
    done     = 1'b0;
    f_in     = f;
    in_valid = 1'b1;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{ln: exp_ln, zero: exp_zero});
        done = 1'b1;
      end
    end
    check("accept_within_bound", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge clk);
    check("drained", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  localparam int NV = 11;
`ifdef LN_LINEAR_INTERP_EN
  localparam logic [31:0] EXP_MAX  = 32'd726815;
  localparam logic [31:0] EXP_7FFF = 32'd681387;
  localparam logic [31:0] EXP_INT  = 32'd1986;
`else
  localparam logic [31:0] EXP_MAX  = 32'd724735;
  localparam logic [31:0] EXP_7FFF = 32'd679309;
  localparam logic [31:0] EXP_INT  = 32'd0;
`endif
  logic [31:0] vec_f  [NV] = '{32'h0002_0000, 32'h0000_8000, 32'h0003_0000, 32'h0001_8000,
                               32'h0001_4000, 32'h0000_0000, 32'h0001_0000, 32'h0000_0001,
                               32'hFFFF_FFFF, 32'h7FFF_0000, 32'h0001_0800};
  logic [31:0] vec_ln [NV] = '{32'h0000_B172, 32'hFFFF_4E8E, 32'h0001_193F, 32'd26573,
                               32'd14624,     32'h8000_0000, 32'h0000_0000, 32'(-726816),
                               EXP_MAX,       EXP_7FFF,      EXP_INT};
  logic        vec_z  [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    f_in      = '0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_ln_out", ln_out, 32'd0);
    check("rst_out_zero", 32'(out_zero), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("in_ready_after_release", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Single beat of 1.0 and its latency
    send(32'h0001_0000, 32'h0, 1'b0);
    @(negedge clk);
    check("latency_c1_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("latency_c2_out_valid", 32'(out_valid), 32'd1 - 32'd1);
    @(negedge clk);
    check("latency_c3_out_valid", 32'(out_valid), 32'd1);
    wait_drain();

    for (int i = 0; i < NV; i++) send(vec_f[i], vec_ln[i], vec_z[i]);
    wait_drain();

    // Reset with three beats in flight
    send(32'h0002_0000, 32'h0000_B172, 1'b0);
    send(32'h0003_0000, 32'h0001_193F, 1'b0);
    send(32'h0000_8000, 32'hFFFF_4E8E, 1'b0);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_ln_out", ln_out, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_rst_no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Back-pressure: credits must start from zero after the reset above
    out_ready = 1'b0;
    send(32'h0001_0000, 32'h0000_0000, 1'b0);
    send(32'h0002_0000, 32'h0000_B172, 1'b0);
    send(32'h0003_0000, 32'h0001_193F, 1'b0);
    check("in_ready_after_3", 32'(in_ready), 32'd1);
    send(32'h0000_8000, 32'hFFFF_4E8E, 1'b0);
    check("in_ready_after_4", 32'(in_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_ln_out", ln_out, 32'h0000_0000);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("in_ready_before_pop", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("in_ready_after_pop", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    send(32'h0004_0000, 32'd90852, 1'b0);
    send(32'h0000_4000, 32'(-90852), 1'b0);
    wait_drain();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("empty_out_valid", 32'(out_valid), 32'd0);
    check("empty_holds_ln_out", ln_out, 32'hFFFE_9D1C);
    check("empty_holds_out_zero", 32'(out_zero), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
